// File: rtl/display_scanner_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the multiplexed seven-segment display blocks.
//   SEG_WIDTH             : width of one encoded segment pattern
//   BLANK_PATTERN_DEFAULT : "all segments off" for active-low segment drivers
//   MAX_DIGITS            : widest anode vector the helper below can build
//   clog2()               : constant-evaluable ceiling log2 for widths
//   anode_onehot_n()      : active-low one-hot anode vector for a digit index
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int SEG_WIDTH = 8;
    localparam logic [SEG_WIDTH-1:0] BLANK_PATTERN_DEFAULT = 8'hFF;
    localparam int MAX_DIGITS = 32;

    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        for (longint unsigned v = 1; v < longint'(value); v = v << 1) begin
            result++;
        end
        return result;
    endfunction

    // Every bit high except the selected digit, which is pulled low.
    function automatic logic [MAX_DIGITS-1:0] anode_onehot_n(input int unsigned index);
        return ~(MAX_DIGITS'(1) << index);
    endfunction

endpackage

// File: rtl/display_scanner_if.sv
// -----------------------------------------------------------------------------
// display_scanner_if
// Bundles the data path between the segment encoders and the display pins.
//   seg_in : DIGITS packed segment patterns, digit i at [8i+7:8i]
//   valid  : single-cycle capture pulse for the latched digits
//   seg    : shared segment bus (active-low segments)
//   an     : per-digit anode enables, active-low
//   held   : latched digits currently show a captured value
// Modports:
//   master : the upstream source / pin observer
//   slave  : the scanner itself
// -----------------------------------------------------------------------------
interface display_scanner_if
    import display_pkg::*;
#(
    parameter int DIGITS = 2
);

    logic [SEG_WIDTH*DIGITS-1:0] seg_in;
    logic                        valid;
    logic [SEG_WIDTH-1:0]        seg;
    logic [DIGITS-1:0]           an;
    logic                        held;

    modport master (
        output seg_in,
        output valid,
        input  seg,
        input  an,
        input  held
    );

    modport slave (
        input  seg_in,
        input  valid,
        output seg,
        output an,
        output held
    );

endinterface

// File: rtl/display_scanner_scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Slot prescaler and digit index for a time-multiplexed display.
//   clk       : system clock
//   rst       : asynchronous reset, active-low
//   presc     : position inside the current digit slot, 0..REFRESH_DIV-1
//   idx       : digit currently being scanned, 0..DIGITS-1
//   tick      : last cycle of the current slot
//   frame_end : last cycle of the last digit's slot (full frame done)
// -----------------------------------------------------------------------------
module scan_timer
    import display_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 50000,
    localparam int PRESC_W    = clog2(REFRESH_DIV),
    localparam int IDX_W      = clog2(DIGITS)
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PRESC_W-1:0] presc,
    output logic [IDX_W-1:0]   idx,
    output logic               tick,
    output logic               frame_end
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

    assign tick      = (presc == PRESC_LAST);
    assign frame_end = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// -----------------------------------------------------------------------------
// display_scanner
// Time-multiplexed seven-segment driver. Digits flagged in LATCH_MASK show a
// value captured on a valid pulse and held until HOLD_FRAMES full frames pass
// without a new capture (0 = hold forever); the other digits track seg_in
// live. The first BLANK_CYCLES cycles of each slot keep every anode off to
// suppress ghosting between digits.
//   clk : system clock
//   rst : asynchronous reset, active-low
//   bus : display_scanner_if.slave (seg_in, valid -> seg, an, held)
// Build option:
//   DISPLAY_SCANNER_BLINK_STALE_EN : a timed-out value is kept and blinked
//   (16 frames on, 16 frames blank) until the next valid instead of blanked.
// -----------------------------------------------------------------------------
module display_scanner
    import display_pkg::*;
#(
    parameter int                   DIGITS        = 2,
    parameter int                   REFRESH_DIV   = 50000,
    parameter int                   BLANK_CYCLES  = 1,
    parameter logic [DIGITS-1:0]    LATCH_MASK    = 2'b10,
    parameter int                   HOLD_FRAMES   = 1000,
    parameter logic [SEG_WIDTH-1:0] BLANK_PATTERN = BLANK_PATTERN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    display_scanner_if.slave  bus
);

    localparam int PRESC_W = clog2(REFRESH_DIV);
    localparam int IDX_W   = clog2(DIGITS);
    localparam int CNT_W   = (HOLD_FRAMES > 0) ? clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);
    localparam logic [PRESC_W-1:0] BLANK_LAST = PRESC_W'(BLANK_CYCLES);

    logic [PRESC_W-1:0]   presc;
    logic [IDX_W-1:0]     idx;
    logic                 tick_unused;
    logic                 frame_end;

    logic [SEG_WIDTH-1:0] seg_arr [DIGITS];
    logic [SEG_WIDTH-1:0] hold    [DIGITS];
    logic                 held_r;
    logic [CNT_W-1:0]     frame_cnt;
    logic                 timeout;
    logic                 hold_clear;
    logic [SEG_WIDTH-1:0] latched_pat;
    logic [SEG_WIDTH-1:0] sel_pat;
    logic                 active;
    logic [DIGITS-1:0]    an_sel;
    logic [SEG_WIDTH-1:0] seg_p1;
    logic [DIGITS-1:0]    an_p1;

    scan_timer #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan_timer (
        .clk       (clk),
        .rst       (rst),
        .presc     (presc),
        .idx       (idx),
        .tick      (tick_unused),
        .frame_end (frame_end)
    );

    for (genvar i = 0; i < DIGITS; i++) begin : g_unpack
        assign seg_arr[i] = bus.seg_in[i*SEG_WIDTH +: SEG_WIDTH];
    end

    // Timeout fires on the frame end that would bring the count to HOLD_FRAMES.
    assign timeout = (HOLD_FRAMES > 0) && held_r && frame_end && (frame_cnt == HOLD_LAST);

    // Capture / hold state; valid takes priority over a coincident timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_r    <= 1'b0;
            frame_cnt <= '0;
        end else if (bus.valid) begin
            held_r    <= 1'b1;
            frame_cnt <= '0;
        end else if (timeout) begin
            held_r    <= 1'b0;
            frame_cnt <= '0;
        end else if (held_r && frame_end && (frame_cnt != '1)) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Live digits never load, so their entries stay at the blank pattern.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DIGITS; i++) hold[i] <= BLANK_PATTERN;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (LATCH_MASK[i]) begin
                    if (bus.valid)       hold[i] <= seg_arr[i];
                    else if (hold_clear) hold[i] <= BLANK_PATTERN;
                end
            end
        end
    end

`ifdef DISPLAY_SCANNER_BLINK_STALE_EN
    logic       stale;
    logic [4:0] blink_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stale     <= 1'b0;
            blink_cnt <= '0;
        end else if (bus.valid) begin
            stale     <= 1'b0;
            blink_cnt <= '0;
        end else if (timeout) begin
            stale     <= 1'b1;
            blink_cnt <= '0;
        end else if (stale && frame_end) begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Upper half of the 32-frame blink period shows blank.
    assign latched_pat = (stale && blink_cnt[4]) ? BLANK_PATTERN : hold[idx];
    assign hold_clear  = 1'b0;
`else
    assign latched_pat = hold[idx];
    assign hold_clear  = timeout;
`endif

    assign sel_pat = LATCH_MASK[idx] ? latched_pat : seg_arr[idx];
    assign active  = (presc >= BLANK_LAST);
    assign an_sel  = DIGITS'(anode_onehot_n(32'(idx)));

    // Stage p1: registered pin drivers, one cycle behind the scan position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_p1 <= BLANK_PATTERN;
            an_p1  <= '1;
        end else begin
            seg_p1 <= active ? sel_pat : BLANK_PATTERN;
            an_p1  <= active ? an_sel  : '1;
        end
    end

    assign bus.seg  = seg_p1;
    assign bus.an   = an_p1;
    assign bus.held = held_r;

endmodule
